// File: rtl/bus_region_decoder.sv
// Registered base/mask address decoder with wait states,
// DTACK/BERR generation, timeout and sticky error capture.
module bus_region_decoder #(
  parameter int NUM_REGIONS    = 8,
  parameter int ADDR_W         = 32,
  parameter int WAIT_W         = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          Clk,
  input  logic                          Reset_H,
  input  logic [ADDR_W-1:0]             Address,
  input  logic                          AS_L,
  input  logic [NUM_REGIONS*ADDR_W-1:0] RegionBase,
  input  logic [NUM_REGIONS*ADDR_W-1:0] RegionMask,
  input  logic [NUM_REGIONS*WAIT_W-1:0] RegionWait,
  input  logic [NUM_REGIONS-1:0]        RegionEnable_H,
  input  logic                          ExtWait_H,
  input  logic                          ErrClr_H,
  output logic [NUM_REGIONS-1:0]        Select_H,
  output logic                          Dtack_L,
  output logic                          Berr_L,
  output logic                          Busy_H,
  output logic                          ErrorFlag_H,
  output logic [ADDR_W-1:0]             ErrorAddress
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WAIT, S_ACK, S_ERROR
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [WAIT_W-1:0]      wcnt_q, wcnt_d;
  logic [CNT_W-1:0]       tcnt_q, tcnt_d;
  logic [NUM_REGIONS-1:0] sel_q, sel_d;
  logic                   dtack_q, dtack_d;
  logic                   berr_q, berr_d;
  logic                   busy_q, busy_d;
  logic                   flag_q, flag_d;
  logic [ADDR_W-1:0]      eaddr_q, eaddr_d;

  logic [NUM_REGIONS-1:0] hit;
  logic [NUM_REGIONS-1:0] onehot;
  logic [WAIT_W-1:0]      hit_wait;
  logic                   timeout;

  // Window match on the latched address, lowest index wins
  always_comb begin
    hit      = '0;
    hit_wait = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      hit[i] = RegionEnable_H[i] &&
        ((addr_q & RegionMask[i*ADDR_W +: ADDR_W]) ==
         (RegionBase[i*ADDR_W +: ADDR_W] &
          RegionMask[i*ADDR_W +: ADDR_W]));
    end
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) hit_wait = RegionWait[i*WAIT_W +: WAIT_W];
    end
    onehot = hit & (~hit + NUM_REGIONS'(1));
  end

  assign timeout = (tcnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = (&tcnt_q) ? tcnt_q : tcnt_q + 1'b1;
    sel_d   = sel_q;
    dtack_d = dtack_q;
    berr_d  = berr_q;
    flag_d  = flag_q & ~ErrClr_H;
    eaddr_d = eaddr_q;
    unique case (state_q)
      S_IDLE: begin
        sel_d   = '0;
        dtack_d = 1'b1;
        berr_d  = 1'b1;
        if (!AS_L) begin
          addr_d  = Address;
          tcnt_d  = '0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (AS_L) begin
          state_d = S_IDLE;
          sel_d   = '0;
        end else if (|hit) begin
          sel_d  = onehot;
          wcnt_d = hit_wait;
          if (hit_wait == '0) begin
            state_d = S_ACK;
            dtack_d = 1'b0;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_ERROR;
          sel_d   = '0;
          berr_d  = 1'b0;
          flag_d  = 1'b1;
          eaddr_d = addr_q;
        end
      end
      S_WAIT: begin
        wcnt_d = (wcnt_q == '0) ? '0 : wcnt_q - 1'b1;
        if (AS_L) begin
          state_d = S_IDLE;
          sel_d   = '0;
        end else if (timeout) begin
          state_d = S_ERROR;
          sel_d   = '0;
          berr_d  = 1'b0;
          flag_d  = 1'b1;
          eaddr_d = addr_q;
        end else if (wcnt_q <= WAIT_W'(1) && !ExtWait_H) begin
          state_d = S_ACK;
          dtack_d = 1'b0;
        end
      end
      S_ACK: begin
        if (AS_L) begin
          state_d = S_IDLE;
          sel_d   = '0;
          dtack_d = 1'b1;
        end
      end
      S_ERROR: begin
        if (AS_L) begin
          state_d = S_IDLE;
          berr_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
        dtack_d = 1'b1;
        berr_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      sel_q   <= '0;
      dtack_q <= 1'b1;
      berr_q  <= 1'b1;
      busy_q  <= 1'b0;
      flag_q  <= 1'b0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      sel_q   <= sel_d;
      dtack_q <= dtack_d;
      berr_q  <= berr_d;
      busy_q  <= busy_d;
      flag_q  <= flag_d;
      eaddr_q <= eaddr_d;
    end
  end

  assign Select_H     = sel_q;
  assign Dtack_L      = dtack_q;
  assign Berr_L       = berr_q;
  assign Busy_H       = busy_q;
  assign ErrorFlag_H  = flag_q;
  assign ErrorAddress = eaddr_q;

endmodule

// File: tb/tb_bus_region_decoder.sv
// Directed testbench for bus_region_decoder.
// Checks latency, priority, errors, timeout and abort.
module tb_bus_region_decoder;

  localparam int NR = 8;
  localparam int AW = 32;
  localparam int WW = 4;
  localparam int TO = 16;

  logic              Clk = 1'b0;
  logic              Reset_H = 1'b1;
  logic [AW-1:0]     Address = '0;
  logic              AS_L = 1'b1;
  logic [NR*AW-1:0]  RegionBase = '0;
  logic [NR*AW-1:0]  RegionMask = '0;
  logic [NR*WW-1:0]  RegionWait = '0;
  logic [NR-1:0]     RegionEnable_H = '0;
  logic              ExtWait_H = 1'b0;
  logic              ErrClr_H = 1'b0;
  logic [NR-1:0]     Select_H;
  logic              Dtack_L;
  logic              Berr_L;
  logic              Busy_H;
  logic              ErrorFlag_H;
  logic [AW-1:0]     ErrorAddress;

  int n_chk = 0;
  int n_fail = 0;

  bus_region_decoder #(
    .NUM_REGIONS(NR), .ADDR_W(AW),
    .WAIT_W(WW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk(Clk), .Reset_H(Reset_H),
    .Address(Address), .AS_L(AS_L),
    .RegionBase(RegionBase),
    .RegionMask(RegionMask),
    .RegionWait(RegionWait),
    .RegionEnable_H(RegionEnable_H),
    .ExtWait_H(ExtWait_H), .ErrClr_H(ErrClr_H),
    .Select_H(Select_H), .Dtack_L(Dtack_L),
    .Berr_L(Berr_L), .Busy_H(Busy_H),
    .ErrorFlag_H(ErrorFlag_H),
    .ErrorAddress(ErrorAddress)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_region(input int i, input logic [AW-1:0] b,
                            input logic [AW-1:0] m,
                            input logic [WW-1:0] w, input logic e);
    RegionBase[i*AW +: AW] = b;
    RegionMask[i*AW +: AW] = m;
    RegionWait[i*WW +: WW] = w;
    RegionEnable_H[i]      = e;
  endtask

  task automatic test_reset();
    Reset_H = 1'b1;
    tick();
    tick();
    Reset_H = 1'b0;
    n_chk++;
    if (Select_H !== 8'h00 || Dtack_L !== 1'b1 || Berr_L !== 1'b1 ||
        Busy_H !== 1'b0 || ErrorFlag_H !== 1'b0 || ErrorAddress !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: sel=%h dt=%b be=%b busy=%b flag=%b ea=%h want 00 1 1 0 0 0",
               Select_H, Dtack_L, Berr_L, Busy_H, ErrorFlag_H, ErrorAddress);
    end
  endtask

  task automatic test_hit_w0();
    set_region(0, 32'h0000_0000, 32'hFFFF_8000, 4'd0, 1'b1);
    Address = 32'h0000_1234;
    AS_L = 1'b0;
    tick();
    n_chk++;
    if (Select_H !== 8'h00 || Dtack_L !== 1'b1 || Busy_H !== 1'b1) begin
      n_fail++;
      $display("FAIL w0_edge_k: sel=%h dt=%b busy=%b want 00 1 1",
               Select_H, Dtack_L, Busy_H);
    end
    tick();
    n_chk++;
    if (Select_H !== 8'h01 || Dtack_L !== 1'b0) begin
      n_fail++;
      $display("FAIL w0_edge_k1: sel=%h dt=%b want 01 0", Select_H, Dtack_L);
    end
    tick();
    n_chk++;
    if (Select_H !== 8'h01 || Dtack_L !== 1'b0) begin
      n_fail++;
      $display("FAIL w0_hold: sel=%h dt=%b want 01 0", Select_H, Dtack_L);
    end
    AS_L = 1'b1;
    tick();
    n_chk++;
    if (Select_H !== 8'h00 || Dtack_L !== 1'b1 || Busy_H !== 1'b0) begin
      n_fail++;
      $display("FAIL w0_release: sel=%h dt=%b busy=%b want 00 1 0",
               Select_H, Dtack_L, Busy_H);
    end
  endtask

  task automatic test_wait3();
    set_region(2, 32'h0800_0000, 32'hFC00_0000, 4'd3, 1'b1);
    Address = 32'h0A00_0010;
    AS_L = 1'b0;
    tick();
    tick();
    n_chk++;
    if (Select_H !== 8'h04 || Dtack_L !== 1'b1) begin
      n_fail++;
      $display("FAIL w3_k1: sel=%h dt=%b want 04 1", Select_H, Dtack_L);
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      n_chk++;
      if (Dtack_L !== 1'b1 || Select_H !== 8'h04) begin
        n_fail++;
        $display("FAIL w3_k%0d: sel=%h dt=%b want 04 1", c, Select_H, Dtack_L);
      end
    end
    tick();
    n_chk++;
    if (Dtack_L !== 1'b0 || Select_H !== 8'h04) begin
      n_fail++;
      $display("FAIL w3_k4: sel=%h dt=%b want 04 0", Select_H, Dtack_L);
    end
    AS_L = 1'b1;
    tick();
    n_chk++;
    if (Dtack_L !== 1'b1 || Select_H !== 8'h00) begin
      n_fail++;
      $display("FAIL w3_release: sel=%h dt=%b want 00 1", Select_H, Dtack_L);
    end
  endtask

  task automatic test_priority();
    set_region(1, 32'h0040_0000, 32'hFFFF_0000, 4'd0, 1'b1);
    set_region(3, 32'h0000_0000, 32'hFF00_0000, 4'd0, 1'b1);
    Address = 32'h0040_0010;
    AS_L = 1'b0;
    tick();
    tick();
    n_chk++;
    if (Select_H !== 8'h02 || Dtack_L !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_r1: sel=%h dt=%b want 02 0", Select_H, Dtack_L);
    end
    AS_L = 1'b1;
    tick();
    RegionEnable_H[1] = 1'b0;
    AS_L = 1'b0;
    tick();
    tick();
    n_chk++;
    if (Select_H !== 8'h08 || Dtack_L !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_r3: sel=%h dt=%b want 08 0", Select_H, Dtack_L);
    end
    AS_L = 1'b1;
    tick();
  endtask

  task automatic test_miss();
    Address = 32'h1234_5678;
    AS_L = 1'b0;
    tick();
    tick();
    n_chk++;
    if (Berr_L !== 1'b0 || Select_H !== 8'h00 || ErrorFlag_H !== 1'b1 ||
        ErrorAddress !== 32'h1234_5678 || Dtack_L !== 1'b1) begin
      n_fail++;
      $display("FAIL miss: be=%b sel=%h flag=%b ea=%h dt=%b want 0 00 1 12345678 1",
               Berr_L, Select_H, ErrorFlag_H, ErrorAddress, Dtack_L);
    end
    AS_L = 1'b1;
    tick();
    tick();
    tick();
    n_chk++;
    if (Berr_L !== 1'b1 || ErrorFlag_H !== 1'b1 || Busy_H !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_sticky: be=%b flag=%b busy=%b want 1 1 0",
               Berr_L, ErrorFlag_H, Busy_H);
    end
    ErrClr_H = 1'b1;
    tick();
    ErrClr_H = 1'b0;
    n_chk++;
    if (ErrorFlag_H !== 1'b0 || ErrorAddress !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL errclr: flag=%b ea=%h want 0 12345678",
               ErrorFlag_H, ErrorAddress);
    end
    Address = 32'h2000_0000;
    AS_L = 1'b0;
    tick();
    ErrClr_H = 1'b1;
    tick();
    ErrClr_H = 1'b0;
    n_chk++;
    if (ErrorFlag_H !== 1'b1 || ErrorAddress !== 32'h2000_0000 ||
        Berr_L !== 1'b0) begin
      n_fail++;
      $display("FAIL set_wins: flag=%b ea=%h be=%b want 1 20000000 0",
               ErrorFlag_H, ErrorAddress, Berr_L);
    end
    AS_L = 1'b1;
    tick();
    ErrClr_H = 1'b1;
    tick();
    ErrClr_H = 1'b0;
  endtask

  task automatic test_timeout();
    set_region(0, 32'h0000_0000, 32'hFFFF_8000, 4'd2, 1'b1);
    Address = 32'h0000_0100;
    ExtWait_H = 1'b1;
    AS_L = 1'b0;
    tick();
    tick();
    n_chk++;
    if (Select_H !== 8'h01 || Berr_L !== 1'b1) begin
      n_fail++;
      $display("FAIL to_k1: sel=%h be=%b want 01 1", Select_H, Berr_L);
    end
    for (int c = 2; c <= 16; c++) begin
      tick();
      n_chk++;
      if (Berr_L !== 1'b1 || Dtack_L !== 1'b1 || Select_H !== 8'h01) begin
        n_fail++;
        $display("FAIL to_k%0d: be=%b dt=%b sel=%h want 1 1 01",
                 c, Berr_L, Dtack_L, Select_H);
      end
    end
    tick();
    n_chk++;
    if (Berr_L !== 1'b0 || Select_H !== 8'h00 || ErrorFlag_H !== 1'b1 ||
        ErrorAddress !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL to_k17: be=%b sel=%h flag=%b ea=%h want 0 00 1 00000100",
               Berr_L, Select_H, ErrorFlag_H, ErrorAddress);
    end
    AS_L = 1'b1;
    ErrClr_H = 1'b1;
    tick();
    ErrClr_H = 1'b0;
  endtask

  task automatic test_abort();
    Address = 32'h0000_0200;
    AS_L = 1'b0;
    tick();
    tick();
    tick();
    AS_L = 1'b1;
    tick();
    n_chk++;
    if (Busy_H !== 1'b0 || Select_H !== 8'h00 || Dtack_L !== 1'b1 ||
        Berr_L !== 1'b1 || ErrorFlag_H !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: busy=%b sel=%h dt=%b be=%b flag=%b want 0 00 1 1 0",
               Busy_H, Select_H, Dtack_L, Berr_L, ErrorFlag_H);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      n_chk++;
      if (Berr_L !== 1'b1 || Dtack_L !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_quiet%0d: be=%b dt=%b want 1 1", c, Berr_L, Dtack_L);
      end
    end
    ExtWait_H = 1'b0;
  endtask

  task automatic test_ext_release();
    Address = 32'h0000_0300;
    ExtWait_H = 1'b1;
    AS_L = 1'b0;
    tick();
    for (int c = 1; c <= 5; c++) tick();
    n_chk++;
    if (Dtack_L !== 1'b1) begin
      n_fail++;
      $display("FAIL ext_hold: dt=%b want 1", Dtack_L);
    end
    ExtWait_H = 1'b0;
    tick();
    n_chk++;
    if (Dtack_L !== 1'b0 || Select_H !== 8'h01) begin
      n_fail++;
      $display("FAIL ext_ack: dt=%b sel=%h want 0 01", Dtack_L, Select_H);
    end
  endtask

  task automatic test_reset_in_ack();
    Reset_H = 1'b1;
    tick();
    Reset_H = 1'b0;
    AS_L = 1'b1;
    n_chk++;
    if (Select_H !== 8'h00 || Dtack_L !== 1'b1 || Busy_H !== 1'b0 ||
        ErrorAddress !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_ack: sel=%h dt=%b busy=%b ea=%h want 00 1 0 0",
               Select_H, Dtack_L, Busy_H, ErrorAddress);
    end
    tick();
    n_chk++;
    if (Busy_H !== 1'b0 || Dtack_L !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b dt=%b want 0 1", Busy_H, Dtack_L);
    end
  endtask

  initial begin
    test_reset();
    test_hit_w0();
    test_wait3();
    test_priority();
    test_miss();
    test_timeout();
    test_abort();
    test_ext_release();
    test_reset_in_ack();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
